fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the instruction decoder. It owns the PC, drives the instruction-memory request, and selects the next PC from sequential, branch, J and JR sources. It also holds the IF/ID pipeline register that the decoder reads. It supports stall from the hazard unit, flush on redirect, and a variable-latency instruction memory.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage_next_pc_sel.sv | 28 ++
 rtl/fetch_stage.sv | 168 ++++++++++++++++
 tb/tb_fetch_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset PC, NOP encoding, fetch FSM states and
// the J-type target helper.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_WAIT    = 2'd1,
      ST_HOLD    = 2'd2,
      ST_DISCARD = 2'd3
   } fetch_state_e;

   function automatic logic [31:0] j_target(input logic [31:0] pc_plus4,
                                            input logic [31:0] instr);
      return {pc_plus4[31:28], instr[25:0], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: branch beats JR beats J beats sequential,
// with a redirect flag whenever a non-sequential source wins.
module next_pc_sel (
   input  logic [31:0] pc_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jr_en_i,
   input  logic [31:0] jr_target_i,
   input  logic        j_en_i,
   input  logic [31:0] j_target_i,
   output logic [31:0] next_pc_o,
   output logic        redirect_o
);

   always_comb begin
      next_pc_o  = pc_i + 32'd4;
      redirect_o = 1'b1;
      if (branch_taken_i)
         next_pc_o = branch_target_i;
      else if (jr_en_i)
         next_pc_o = jr_target_i;
      else if (j_en_i)
         next_pc_o = j_target_i;
      else
         redirect_o = 1'b0;
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem request FSM, one-entry stall buffer
// and the IF/ID pipeline register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         branch_taken,
   input  logic [31:0]  branch_target,
   input  logic [31:0]  jr_target,
   input  logic         id_j,
   input  logic         id_jr,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ready,
   input  logic [31:0]  imem_data,
   output logic [31:0]  if_id_instr,
   output logic [31:0]  if_id_pc_plus4,
   output logic         if_id_valid,
   output fetch_state_e dbg_state
);

   fetch_state_e state_q;
   logic [31:0]  pc_q, pend_q, buf_instr_q, buf_pc4_q;
   logic [31:0]  if_id_instr_q, if_id_pc4_q;
   logic         buf_valid_q, if_id_valid_q;

   logic [31:0]  pc_plus4, next_pc;
   logic         redirect, j_en, jr_en;

   assign pc_plus4 = pc_q + 32'd4;
   // J/JR only act on a real instruction that the decoder is actually consuming.
   assign j_en     = id_j  & if_id_valid_q & ~stall;
   assign jr_en    = id_jr & if_id_valid_q & ~stall;

   next_pc_sel u_next_pc_sel (
      .pc_i            (pc_q),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jr_en_i         (jr_en),
      .jr_target_i     (jr_target),
      .j_en_i          (j_en),
      .j_target_i      (j_target(if_id_pc4_q, if_id_instr_q)),
      .next_pc_o       (next_pc),
      .redirect_o      (redirect)
   );

   always_comb begin
      imem_req = 1'b0;
      case (state_q)
         ST_FETCH:   imem_req = ~stall;
         ST_WAIT:    imem_req = 1'b1;
         ST_DISCARD: imem_req = 1'b1;
         ST_HOLD:    imem_req = 1'b0;
         default:    imem_req = 1'b0;
      endcase
      if (reset)
         imem_req = 1'b0;
   end

   assign imem_addr      = pc_q;
   assign if_id_instr    = if_id_instr_q;
   assign if_id_pc_plus4 = if_id_pc4_q;
   assign if_id_valid    = if_id_valid_q;
   assign dbg_state      = state_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         pend_q        <= 32'h0;
         buf_instr_q   <= NOP;
         buf_pc4_q     <= 32'h0;
         buf_valid_q   <= 1'b0;
         if_id_instr_q <= NOP;
         if_id_pc4_q   <= 32'h0;
         if_id_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_FETCH: begin
               if (redirect) begin
                  if_id_instr_q <= NOP;
                  if_id_valid_q <= 1'b0;
                  buf_valid_q   <= 1'b0;
                  // An unanswered request must stay on the bus, so park the target.
                  if (imem_req && !imem_ready) begin
                     pend_q  <= next_pc;
                     state_q <= ST_DISCARD;
                  end else begin
                     pc_q <= next_pc;
                  end
               end else if (!stall) begin
                  if (imem_ready) begin
                     if_id_instr_q <= imem_data;
                     if_id_pc4_q   <= pc_plus4;
                     if_id_valid_q <= 1'b1;
                     pc_q          <= pc_plus4;
                  end else begin
                     if_id_instr_q <= NOP;
                     if_id_valid_q <= 1'b0;
                     state_q       <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (redirect) begin
                  if_id_instr_q <= NOP;
                  if_id_valid_q <= 1'b0;
                  if (imem_ready) begin
                     pc_q    <= next_pc;
                     state_q <= ST_FETCH;
                  end else begin
                     pend_q  <= next_pc;
                     state_q <= ST_DISCARD;
                  end
               end else if (imem_ready) begin
                  pc_q <= pc_plus4;
                  if (stall) begin
                     buf_instr_q <= imem_data;
                     buf_pc4_q   <= pc_plus4;
                     buf_valid_q <= 1'b1;
                     state_q     <= ST_HOLD;
                  end else begin
                     if_id_instr_q <= imem_data;
                     if_id_pc4_q   <= pc_plus4;
                     if_id_valid_q <= 1'b1;
                     state_q       <= ST_FETCH;
                  end
               end else if (!stall) begin
                  if_id_instr_q <= NOP;
                  if_id_valid_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (redirect) begin
                  if_id_instr_q <= NOP;
                  if_id_valid_q <= 1'b0;
                  buf_valid_q   <= 1'b0;
                  pc_q          <= next_pc;
                  state_q       <= ST_FETCH;
               end else if (!stall) begin
                  if_id_instr_q <= buf_valid_q ? buf_instr_q : NOP;
                  if_id_pc4_q   <= buf_pc4_q;
                  if_id_valid_q <= buf_valid_q;
                  buf_valid_q   <= 1'b0;
                  state_q       <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if_id_instr_q <= NOP;
               if_id_valid_q <= 1'b0;
               if (redirect)
                  pend_q <= next_pc;
               // The returning word belongs to the squashed path and is dropped.
               if (imem_ready) begin
                  pc_q    <= redirect ? next_pc : pend_q;
                  state_q <= ST_FETCH;
               end
            end
            default: state_q <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-by-cycle driver with hand-computed
// addresses and a scoreboard of instructions expected to reach IF/ID.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic         clk = 1'b0;
   logic         reset, stall, branch_taken, id_j, id_jr, imem_ready;
   logic [31:0]  branch_target, jr_target, imem_data;
   logic         imem_req, if_id_valid;
   logic [31:0]  imem_addr, if_id_instr, if_id_pc_plus4;
   fetch_state_e dbg_state;

   logic         ovr_en = 1'b0;
   logic [31:0]  ovr_data = 32'h0;
   logic         st_edge = 1'b0;
   logic         rst_edge = 1'b1;
   logic [63:0]  exp_q[$];
   logic [63:0]  mon_e;
   int           n_cmp = 0;
   int           n_bad = 0;

   fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .jr_target      (jr_target),
      .id_j           (id_j),
      .id_jr          (id_jr),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_data      (imem_data),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_valid    (if_id_valid),
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_at(input logic [31:0] a);
      return {16'h2408, a[15:0]};
   endfunction

   // Memory model: answers with a per-address word, or a forced word.
   assign imem_data = ovr_en ? ovr_data : instr_at(imem_addr);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] instr);
      exp_q.push_back({instr, a + 32'd4});
   endtask

   task automatic drive(input string lbl, input logic rst, input logic st, input logic rdy,
                        input logic br, input logic [31:0] bt, input logic j, input logic jr,
                        input logic ev, input logic er, input logic [31:0] ea);
      reset = rst; stall = st; imem_ready = rdy;
      branch_taken = br; branch_target = bt; id_j = j; id_jr = jr;
      #1;
      chk({lbl, "_valid"}, 64'(if_id_valid), 64'(ev));
      chk({lbl, "_req"},   64'(imem_req),    64'(er));
      chk({lbl, "_addr"},  64'(imem_addr),   64'(ea));
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      st_edge  <= stall;
      rst_edge <= reset;
   end

   // Monitor: a valid IF/ID after a non-stalled, non-reset edge is a new instruction.
   always @(negedge clk) begin
      if (if_id_valid && !st_edge && !rst_edge) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got %h/%h expected none", if_id_instr, if_id_pc_plus4);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_ifid", {if_id_instr, if_id_pc_plus4}, mon_e);
         end
      end else if (!if_id_valid) begin
         chk("bubble_nop", 64'(if_id_instr), 64'h0);
      end
   end

   initial begin
      reset = 1'b1; stall = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
      branch_target = 32'h0; jr_target = 32'h0; id_j = 1'b0; id_jr = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req",   64'(imem_req),       64'h0);
      chk("rst_valid", 64'(if_id_valid),    64'h0);
      chk("rst_instr", 64'(if_id_instr),    64'h0);
      chk("rst_pc4",   64'(if_id_pc_plus4), 64'h0);
      chk("rst_state", 64'(dbg_state),      64'(ST_FETCH));
      @(negedge clk);

      // Zero-wait sequential fetch, then two wait cycles at 8.
      push(32'h0, instr_at(32'h0));
      drive("c1",  0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      push(32'h4, instr_at(32'h4));
      drive("c2",  0, 0, 1, 0, 32'h0, 0, 0, 1, 1, 32'h4);
      drive("c3",  0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h8);
      drive("c4",  0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h8);
      push(32'h8, instr_at(32'h8));
      drive("c5",  0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h8);
      push(32'hC, instr_at(32'hC));
      drive("c6",  0, 0, 1, 0, 32'h0, 0, 0, 1, 1, 32'hC);

      // Branch while the fetch at 16 is outstanding: DISCARD, data dropped.
      drive("c7",  0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h10);
      drive("c8",  0, 0, 0, 1, 32'h40, 0, 0, 0, 1, 32'h10);
      chk("discard_state", 64'(dbg_state), 64'(ST_DISCARD));
      drive("c9",  0, 0, 0, 0, 32'h0, 0, 0, 0, 1, 32'h10);
      drive("c10", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h10);
      push(32'h40, instr_at(32'h40));
      drive("c11", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h40);

      // Branch with zero-wait memory, target holds a J 0x100.
      drive("c12", 0, 0, 1, 1, 32'h1000_0004, 0, 0, 1, 1, 32'h44);
      ovr_en = 1'b1; ovr_data = 32'h0800_0100;
      push(32'h1000_0004, 32'h0800_0100);
      drive("c13", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h1000_0004);
      ovr_en = 1'b0;
      drive("c14", 0, 0, 1, 0, 32'h0, 1, 0, 1, 1, 32'h1000_0008);
      push(32'h1000_0400, instr_at(32'h1000_0400));
      drive("c15", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h1000_0400);

      // Ready arrives under a three-cycle stall: buffered in HOLD.
      drive("c16", 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h1000_0404);
      push(32'h1000_0404, instr_at(32'h1000_0404));
      drive("c17", 0, 1, 1, 0, 32'h0, 0, 0, 0, 1, 32'h1000_0404);
      chk("hold_state", 64'(dbg_state), 64'(ST_HOLD));
      drive("c18", 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h1000_0408);
      drive("c19", 0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h1000_0408);
      drive("c20", 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h1000_0408);

      // JR held off by stall, taken once stall drops.
      jr_target = 32'h200;
      drive("c21", 0, 1, 0, 0, 32'h0, 0, 1, 1, 0, 32'h1000_0408);
      drive("c22", 0, 1, 0, 0, 32'h0, 0, 1, 1, 0, 32'h1000_0408);
      drive("c23", 0, 0, 1, 0, 32'h0, 0, 1, 1, 1, 32'h1000_0408);
      push(32'h200, instr_at(32'h200));
      drive("c24", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h200);

      // Branch overrides stall; then PC wraps from FFFF_FFFC to 0.
      drive("c25", 0, 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0, 32'h204);
      push(32'hFFFF_FFFC, instr_at(32'hFFFF_FFFC));
      drive("c26", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      push(32'h0, instr_at(32'h0));
      drive("c27", 0, 0, 1, 0, 32'h0, 0, 0, 1, 1, 32'h0);
      drive("c28", 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h4);
      chk("wait_state", 64'(dbg_state), 64'(ST_WAIT));

      // Reset mid-WAIT with a late ready: ignored, restart at RESET_PC.
      drive("c29", 1, 0, 1, 0, 32'h0, 0, 0, 0, 0, 32'h4);
      chk("rstw_state", 64'(dbg_state),      64'(ST_FETCH));
      chk("rstw_instr", 64'(if_id_instr),    64'h0);
      chk("rstw_pc4",   64'(if_id_pc_plus4), 64'h0);
      push(32'h0, instr_at(32'h0));
      drive("c30", 0, 0, 1, 0, 32'h0, 0, 0, 0, 1, 32'h0);
      drive("c31", 0, 0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h4);
      @(negedge clk);
      chk("sb_drained", 64'(exp_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
